lane_demux_collector: RTL and testbench
=======================================

Name: lane_demux_collector

Overview:
- Inverse of the 4:1 two-bit lane mux that drives the board LEDs from the switch bank.
- Accepts a stream of (lane select, W-bit data) writes over a valid/ready handshake and steers each write into one of LANES lane registers.
- Presents the assembled LANES*W-bit word on a valid/ready output once every lane is filled, or on flush.
- Sits between the switch/input front end and any consumer of the packed word, for example the LED/segment drivers.

Parameters:
- W, 2, width of each lane in bits.
- LANES, 4, number of lanes; select width is log2(LANES) = 2.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  write request valid.
- io_in_ready  output  1  block can accept a write this cycle.
- io_in_bits_select  input  2  destination lane index.
- io_in_bits_data  input  W  lane data.
- io_flush  input  1  force emission of a partially filled word.
- io_out_valid  output  1  assembled word available.
- io_out_ready  input  1  consumer accepts the word.
- io_out_bits_data  output  LANES*W  packed word; lane i occupies bits [W*i+W-1 : W*i], so lane 0 is at the LSBs.
- io_out_bits_mask  output  LANES  bit i set when lane i was written.
- io_out_bits_dup  output  1  at least one lane was written more than once in this word.

Behaviour:
- Reset values:
  - State is COLLECT.
  - All lane registers, mask and dup are 0.
  - io_out_valid = 0 and io_in_ready = 1 in the cycle after reset.
- Reset mid-operation discards any partial or held word, with no output handshake.
- State COLLECT:
  - io_in_ready = 1 and io_out_valid = 0.
  - Accept when io_in_valid && io_in_ready: lane[select] <= data and mask[select] <= 1.
  - If mask[select] was already 1, lane data is overwritten (last write wins) and dup <= 1 (sticky for this word).
- Transition COLLECT -> HOLD at the next edge when either:
  - the post-accept mask is all ones, or
  - io_flush = 1 and the post-accept mask is non-zero.
- Flush and accept in the same cycle: the accept is applied first, then the flush is evaluated.
- io_flush with an empty mask and no accept is ignored; the block stays in COLLECT.
- State HOLD:
  - io_out_valid = 1 and io_in_ready = 0.
  - Input writes are not accepted and io_flush is ignored.
  - io_out_bits_* are taken directly from the lane, mask and dup registers and are stable until the handshake.
  - Unwritten lanes read as 0.
- Transition HOLD -> COLLECT:
  - On io_out_valid && io_out_ready, clear lanes, mask and dup at the same edge and return to COLLECT.
  - There is no same-cycle input accept on the handshake cycle, since in_ready = 0 in HOLD.
- Latency: the write that completes the word is accepted at edge N; io_out_valid = 1 from cycle N+1.
  - Minimum full-word period: LANES accept cycles plus 1 output cycle.
- io_out_ready held low keeps the block in HOLD indefinitely with outputs frozen (backpressure).
- io_in_valid low in COLLECT holds all state.
- Select is always in range for LANES = 4. For non-power-of-two LANES, out-of-range selects are accepted and dropped, setting dup.
- io_out_valid depends only on registered state; there is no combinational path from io_in_* or io_out_ready to outputs.
  - io_in_ready is likewise derived from state only.

Test Plan:
1. Reset, then writes (sel,data) = (0,1), (1,2), (2,3), (3,0) on consecutive cycles with out_ready = 1 -> out_valid one cycle after the 4th accept; data = 8'b00111001, mask = 4'hF, dup = 0; in_ready returns to 1 the next cycle.
2. Writes (2,3), (2,1), (0,2), (1,1), (3,3) -> single output: data = 8'b11010110, dup = 1, mask = 4'hF.
3. Write (1,3), then io_flush -> out_valid next cycle; data = 8'h0C, mask = 4'b0010; io_flush alone with an empty mask -> no out_valid for 5 cycles.
4. Full word with out_ready = 0 for 6 cycles while in_valid stays high with varying data -> out_valid held, data unchanged, in_ready = 0 throughout; raise out_ready -> one handshake, then COLLECT with mask = 0.
5. Write (3,2) together with io_flush in the same cycle -> out data = 8'h80, mask = 4'b1000.
6. Assert reset during HOLD with a full word -> next cycle out_valid = 0, in_ready = 1; next full word shows no stale bits or dup.

Source files
------------

// File: rtl/lane_demux_collector.sv
// Lane demux collector: steers (select, data) writes into LANES lane registers
// and emits the packed word over valid/ready once all lanes are filled or on flush.
module lane_demux_collector #(
    parameter int unsigned W     = 2,
    parameter int unsigned LANES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] io_in_bits_select,
    input  logic [W-1:0]         io_in_bits_data,
    input  logic                 io_flush,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [LANES*W-1:0]   io_out_bits_data,
    output logic [LANES-1:0]     io_out_bits_mask,
    output logic                 io_out_bits_dup
);

    localparam int unsigned SEL_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned WORD_W = LANES * W;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [WORD_W-1:0]   data_q;
    logic [WORD_W-1:0]   data_d;
    logic [LANES-1:0]    mask_q;
    logic [LANES-1:0]    mask_d;
    logic                dup_q;
    logic                dup_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                accept_c;
    logic                lane_hit_c;

    // Next-state and datapath update; accept is applied before the flush decision.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mask_d     = mask_q;
        dup_d      = dup_q;
        accept_c   = 1'b0;
        lane_hit_c = 1'b0;

        case (state_q)
            COLLECT: begin
                accept_c = io_in_valid && in_ready_q;
                if (accept_c) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (io_in_bits_select == SEL_W'(i)) begin
                            lane_hit_c          = 1'b1;
                            data_d[i*W +: W]    = io_in_bits_data;
                            mask_d[i]           = 1'b1;
                            if (mask_q[i]) begin
                                dup_d = 1'b1;
                            end
                        end
                    end
                    // Out-of-range select (non-power-of-two LANES) is dropped and flagged.
                    if (!lane_hit_c) begin
                        dup_d = 1'b1;
                    end
                end
                if ((&mask_d) || (io_flush && (|mask_d))) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (out_valid_q && io_out_ready) begin
                    state_d = COLLECT;
                    data_d  = '0;
                    mask_d  = '0;
                    dup_d   = 1'b0;
                end
            end

            default: begin
                state_d = COLLECT;
                data_d  = '0;
                mask_d  = '0;
                dup_d   = 1'b0;
            end
        endcase
    end

    // State, lane storage and handshake flags; flags mirror the next state so
    // they come straight from flops with no path from the inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= COLLECT;
            data_q      <= '0;
            mask_q      <= '0;
            dup_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            dup_q       <= dup_d;
            in_ready_q  <= (state_d == COLLECT);
            out_valid_q <= (state_d == HOLD);
        end
    end

    // Outputs are the registers themselves; unwritten lanes stay 0.
    assign io_in_ready      = in_ready_q;
    assign io_out_valid     = out_valid_q;
    assign io_out_bits_data = data_q;
    assign io_out_bits_mask = mask_q;
    assign io_out_bits_dup  = dup_q;

endmodule

// File: tb/tb_lane_demux_collector.sv
// Self-checking bench for lane_demux_collector against a word-level model.
module tb_lane_demux_collector;

    localparam int unsigned W      = 2;
    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = LANES * W;

    logic                clock;
    logic                reset;
    logic                io_in_valid;
    logic                io_in_ready;
    logic [1:0]          io_in_bits_select;
    logic [W-1:0]        io_in_bits_data;
    logic                io_flush;
    logic                io_out_valid;
    logic                io_out_ready;
    logic [WORD_W-1:0]   io_out_bits_data;
    logic [LANES-1:0]    io_out_bits_mask;
    logic                io_out_bits_dup;

    int n_checks;
    int n_fail;
    int n_words;

    // Reference model: a word being assembled, plus whether it is on offer.
    int          m_lane [LANES];
    bit [LANES-1:0] m_mask;
    bit          m_dup;
    bit          m_hold;

    lane_demux_collector #(.W(W), .LANES(LANES)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_bits_select (io_in_bits_select),
        .io_in_bits_data   (io_in_bits_data),
        .io_flush          (io_flush),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_bits_data  (io_out_bits_data),
        .io_out_bits_mask  (io_out_bits_mask),
        .io_out_bits_dup   (io_out_bits_dup)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_clear();
        for (int i = 0; i < LANES; i++) m_lane[i] = 0;
        m_mask = '0;
        m_dup  = 1'b0;
        m_hold = 1'b0;
    endfunction

    // One clock edge of the block's observable behaviour.
    function automatic void model_edge(bit rst, bit v, int sel, int d, bit fl, bit ordy);
        if (rst) begin
            model_clear();
            return;
        end
        if (m_hold) begin
            if (ordy) begin
                model_clear();
                n_words++;
            end
            return;
        end
        if (v) begin
            if (m_mask[sel]) m_dup = 1'b1;
            m_lane[sel] = d;
            m_mask[sel] = 1'b1;
        end
        if (m_mask == {LANES{1'b1}} || (fl && m_mask != 0)) m_hold = 1'b1;
    endfunction

    function automatic logic [WORD_W-1:0] model_word();
        int acc;
        acc = 0;
        for (int i = 0; i < LANES; i++) acc += m_lane[i] * (1 << (W * i));
        return WORD_W'(acc);
    endfunction

    // Drive one cycle of inputs, advance the model, step past the edge.
    task automatic drive(input bit rst, input bit v, input int sel, input int d,
                         input bit fl, input bit ordy);
        reset             = rst;
        io_in_valid       = v;
        io_in_bits_select = 2'(sel);
        io_in_bits_data   = W'(d);
        io_flush          = fl;
        io_out_ready      = ordy;
        model_edge(rst, v && !m_hold, sel, d, fl, ordy);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 1'b0, 0, 0, 1'b0, ordy);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2, 3, 1'b1, 1'b1);
        idle(1'b0);
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", io_out_valid); end
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", io_in_ready); end
        n_checks++; if (io_out_bits_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", io_out_bits_data); end
        n_checks++; if (io_out_bits_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", io_out_bits_mask); end
        n_checks++; if (io_out_bits_dup !== 1'b0) begin n_fail++; $display("FAIL reset_dup: got %0b want 0", io_out_bits_dup); end
    endtask

    task automatic test_full_word();
        drive(1'b0, 1'b1, 0, 1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1, 2, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 2, 3, 1'b0, 1'b1);
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %0b want 0", io_out_valid); end
        drive(1'b0, 1'b1, 3, 0, 1'b0, 1'b1);
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %0b want 1", io_out_valid); end
        n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %0b want 0", io_in_ready); end
        n_checks++; if (io_out_bits_data !== 8'b00111001 || io_out_bits_data !== model_word()) begin n_fail++; $display("FAIL full_data: got %b want 00111001", io_out_bits_data); end
        n_checks++; if (io_out_bits_mask !== 4'hF) begin n_fail++; $display("FAIL full_mask: got %h want f", io_out_bits_mask); end
        n_checks++; if (io_out_bits_dup !== 1'b0) begin n_fail++; $display("FAIL full_dup: got %0b want 0", io_out_bits_dup); end
        idle(1'b1);
        n_checks++; if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_return: got ready=%0b valid=%0b want 1/0", io_in_ready, io_out_valid); end
        n_checks++; if (io_out_bits_mask !== 4'h0) begin n_fail++; $display("FAIL full_cleared_mask: got %h want 0", io_out_bits_mask); end
    endtask

    task automatic test_dup();
        drive(1'b0, 1'b1, 2, 3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2, 1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL dup_early_valid: got %0b want 0", io_out_valid); end
        drive(1'b0, 1'b1, 3, 3, 1'b0, 1'b0);
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL dup_valid: got %0b want 1", io_out_valid); end
        n_checks++; if (io_out_bits_data !== 8'b11010110 || io_out_bits_data !== model_word()) begin n_fail++; $display("FAIL dup_data: got %b want 11010110", io_out_bits_data); end
        n_checks++; if (io_out_bits_dup !== 1'b1) begin n_fail++; $display("FAIL dup_flag: got %0b want 1", io_out_bits_dup); end
        n_checks++; if (io_out_bits_mask !== 4'hF) begin n_fail++; $display("FAIL dup_mask: got %h want f", io_out_bits_mask); end
        idle(1'b1);
        n_checks++; if (io_out_bits_dup !== 1'b0 || io_out_valid !== 1'b0) begin n_fail++; $display("FAIL dup_clear: got dup=%0b valid=%0b want 0/0", io_out_bits_dup, io_out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 1, 3, 1'b0, 1'b0);
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early_valid: got %0b want 0", io_out_valid); end
        drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %0b want 1", io_out_valid); end
        n_checks++; if (io_out_bits_data !== 8'h0C) begin n_fail++; $display("FAIL flush_data: got %h want 0c", io_out_bits_data); end
        n_checks++; if (io_out_bits_mask !== 4'b0010) begin n_fail++; $display("FAIL flush_mask: got %b want 0010", io_out_bits_mask); end
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
            n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid[%0d]: got %0b want 0", i, io_out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] held;
        for (int i = 0; i < LANES; i++) drive(1'b0, 1'b1, i, $urandom_range(3), 1'b0, 1'b0);
        held = model_word();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, $urandom_range(3), $urandom_range(3), $urandom_range(1), 1'b0);
            n_checks++; if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_flags[%0d]: got valid=%0b ready=%0b want 1/0", i, io_out_valid, io_in_ready); end
            n_checks++; if (io_out_bits_data !== held) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, io_out_bits_data, held); end
        end
        idle(1'b1);
        n_checks++; if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%0b ready=%0b want 0/1", io_out_valid, io_in_ready); end
        n_checks++; if (io_out_bits_mask !== 4'h0) begin n_fail++; $display("FAIL bp_mask: got %h want 0", io_out_bits_mask); end
        idle(1'b1);
        n_checks++; if (n_words != 4) begin n_fail++; $display("FAIL bp_word_count: got %0d want 4", n_words); end
    endtask

    task automatic test_flush_accept();
        drive(1'b0, 1'b1, 3, 2, 1'b1, 1'b0);
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL fa_valid: got %0b want 1", io_out_valid); end
        n_checks++; if (io_out_bits_data !== 8'h80) begin n_fail++; $display("FAIL fa_data: got %h want 80", io_out_bits_data); end
        n_checks++; if (io_out_bits_mask !== 4'b1000) begin n_fail++; $display("FAIL fa_mask: got %b want 1000", io_out_bits_mask); end
        idle(1'b1);
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < LANES; i++) drive(1'b0, 1'b1, i, 3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL rh_hold: got %0b want 1", io_out_valid); end
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        n_checks++; if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin n_fail++; $display("FAIL rh_after_reset: got valid=%0b ready=%0b want 0/1", io_out_valid, io_in_ready); end
        for (int i = LANES - 1; i >= 0; i--) drive(1'b0, 1'b1, i, $urandom_range(3), 1'b0, 1'b0);
        n_checks++; if (io_out_bits_data !== model_word() || io_out_bits_dup !== 1'b0 || io_out_bits_mask !== 4'hF) begin n_fail++; $display("FAIL rh_fresh_word: got %h/%0b/%h want %h/0/f", io_out_bits_data, io_out_bits_dup, io_out_bits_mask, model_word()); end
        idle(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3),
                  ($urandom_range(7) == 0), 1'($urandom_range(1)));
            n_checks++; if (io_out_valid !== m_hold || io_in_ready !== !m_hold) begin n_fail++; $display("FAIL rnd_flags[%0d]: got valid=%0b ready=%0b want %0b/%0b", i, io_out_valid, io_in_ready, m_hold, !m_hold); end
            if (m_hold) begin
                n_checks++; if (io_out_bits_data !== model_word() || io_out_bits_mask !== m_mask || io_out_bits_dup !== m_dup) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h/%h/%0b want %h/%h/%0b", i, io_out_bits_data, io_out_bits_mask, io_out_bits_dup, model_word(), m_mask, m_dup); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_words  = 0;
        model_clear();
        reset = 1'b1; io_in_valid = 1'b0; io_in_bits_select = '0;
        io_in_bits_data = '0; io_flush = 1'b0; io_out_ready = 1'b0;
        test_reset();
        test_full_word();
        test_dup();
        test_flush();
        test_backpressure();
        test_flush_accept();
        test_reset_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
